// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage.
// Holds funct3 codes, the FSM state type and store lane-steering functions.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic f3_legal(input logic [2:0] funct3);
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic f3_misaligned(
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte enables for the addressed lane(s); unsigned codes share the
    // signed lane pattern.
    function automatic logic [3:0] store_be(
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << addr_lo;
            F3_H, F3_HU: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum across all lanes so the slave can pick
    // whichever lane the byte enables select.
    function automatic logic [31:0] store_wdata(
        input logic [2:0]  funct3,
        input logic [31:0] data
    );
        logic [31:0] wd;
        case (funct3)
            F3_B, F3_BU: wd = {4{data[7:0]}};
            F3_H, F3_HU: wd = {2{data[15:0]}};
            default:     wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension (combinational).
// Ports: rdata_i word from memory, addr_lo_i byte offset, funct3_i size/sign code, data_o result.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'b0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'b0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: single-outstanding req/ack data-bus access with lane steering.
// Ports: EX/MEM request (mem_*_in, alu_result_in, ram_data_in), dmem_* bus, mem_stall, load/error outputs.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  mem_funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] ram_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] load_data_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lo_q, lo_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] ld_q, ld_d;
    logic        err_q, err_d;

    logic        access;
    logic        bad;
    logic [2:0]  f3_eff;
    logic [31:0] ext_data;

    assign access = mem_read_in | mem_write_in;
    assign bad = !f3_legal(mem_funct3_in)
               | f3_misaligned(mem_funct3_in, alu_result_in[1:0]);

    // Stores have no signedness, so BU/HU collapse onto B/H.
    assign f3_eff = (mem_write_in && mem_funct3_in[2])
                  ? {1'b0, mem_funct3_in[1:0]}
                  : mem_funct3_in;

    load_extend u_ext (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (lo_q),
        .funct3_i  (f3_q),
        .data_o    (ext_data)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        lo_d           = lo_q;
        f3_d           = f3_q;
        ld_d           = ld_q;
        err_d          = 1'b0;
        mem_stall      = 1'b0;
        misaligned_out = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (access && bad) begin
                    misaligned_out = 1'b1;
                end else if (access) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = mem_write_in;
                    addr_d    = {alu_result_in[31:2], 2'b00};
                    be_d      = store_be(f3_eff, alu_result_in[1:0]);
                    wdata_d   = store_wdata(f3_eff, ram_data_in);
                    lo_d      = alu_result_in[1:0];
                    f3_d      = f3_eff;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    if (!we_q) begin
                        ld_d = ext_data;
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    ld_d    = 32'd0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            lo_q    <= 2'd0;
            f3_q    <= 3'd0;
            ld_q    <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            f3_q    <= f3_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_be       = be_q;
    assign dmem_wdata    = wdata_q;
    assign load_data_out = ld_q;
    assign bus_err_out   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: vector table, hand sequences, random vs reference model.
// Slave ack timing is driven per access; expectations come from tables or the model.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in;
    logic [2:0]  mem_funct3_in;
    logic [31:0] alu_result_in, ram_data_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        mem_stall, misaligned_out, bus_err_out;
    logic [31:0] load_data_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [31:0] ld_model = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read_in    (mem_read_in),
        .mem_write_in   (mem_write_in),
        .mem_funct3_in  (mem_funct3_in),
        .alu_result_in  (alu_result_in),
        .ram_data_in    (ram_data_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .mem_stall      (mem_stall),
        .load_data_out  (load_data_out),
        .misaligned_out (misaligned_out),
        .bus_err_out    (bus_err_out)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          ackn;
        bit          e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_inputs();
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        mem_funct3_in = 3'd0;
        alu_result_in = 32'd0;
        ram_data_in   = 32'd0;
    endtask

    // Reference model: expected lanes and load result from size/sign rules.
    task automatic model(
        input bit rd, input bit wr, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] rs2,
        input logic [31:0] rdata, input int ackn,
        output bit mis, output logic [3:0] be,
        output logic [31:0] wd, output logic [31:0] ld
    );
        int sz;
        int lo;
        bit uns;
        logic [31:0] sh;
        sz  = int'(f3[1:0]);
        lo  = int'(addr[1:0]);
        uns = f3[2];
        mis = (f3 == 3'd3) || (f3 >= 3'd6);
        if (!mis) mis = (sz == 1 && addr[0]) || (sz == 2 && lo != 0);
        be = (sz == 0) ? 4'(1 << lo) : (sz == 1) ? 4'(3 << lo) : 4'hF;
        wd = (sz == 0) ? {4{rs2[7:0]}} : (sz == 1) ? {2{rs2[15:0]}} : rs2;
        ld = ld_model;
        if (!mis && (rd || wr)) begin
            if (ackn == 0 || ackn > TO) ld = 32'd0;
            else if (!wr) begin
                sh = rdata >> (8 * lo);
                if (sz == 2)      ld = rdata;
                else if (sz == 1) ld = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                else              ld = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
        end
    endtask

    // Runs one access; entered #1 after a posedge with the DUT in IDLE.
    // ackn: BUSY cycle in which the slave acks (0 = never).
    task automatic do_access(input string tag, input vec_t v);
        int  busy;
        int  stalls;
        int  e_busy;
        bit  e_err;
        bit  done;
        mem_read_in   = v.rd;
        mem_write_in  = v.wr;
        mem_funct3_in = v.f3;
        alu_result_in = v.addr;
        ram_data_in   = v.rs2;
        @(negedge clk);
        if (v.e_mis) begin
            chk({tag, ".mis"}, 32'(misaligned_out), 32'd1);
            chk({tag, ".mis_stall"}, 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
            clear_inputs();
            @(negedge clk);
            chk({tag, ".mis_pulse"}, 32'(misaligned_out), 32'd0);
            chk({tag, ".mis_noreq"}, 32'(dmem_req), 32'd0);
            chk({tag, ".mis_ld"}, load_data_out, v.e_ld);
            @(posedge clk); #1;
            ld_model = v.e_ld;
            return;
        end
        chk({tag, ".stall0"}, 32'(mem_stall), 32'd1);
        chk({tag, ".nomis"}, 32'(misaligned_out), 32'd0);
        stalls = 1;
        busy = 0;
        done = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 40 && !done; c++) begin
            busy++;
            dmem_ack   = (v.ackn != 0 && busy == v.ackn);
            dmem_rdata = dmem_ack ? v.rdata : $urandom;
            @(negedge clk);
            if (mem_stall) stalls++;
            chk({tag, ".req"}, 32'(dmem_req), 32'd1);
            if (busy == 1) begin
                chk({tag, ".we"}, 32'(dmem_we), 32'(v.wr));
                chk({tag, ".addr"}, dmem_addr, {v.addr[31:2], 2'b00});
                chk({tag, ".be"}, 32'(dmem_be), 32'(v.e_be));
                if (v.wr) chk({tag, ".wdata"}, dmem_wdata, v.e_wdata);
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (!dmem_req) done = 1'b1;
        end
        if (!done) chk({tag, ".bound"}, 32'd0, 32'd1);
        clear_inputs();
        e_err  = (v.ackn == 0 || v.ackn > TO);
        e_busy = e_err ? TO : v.ackn;
        @(negedge clk);
        chk({tag, ".busy_cycles"}, 32'(busy), 32'(e_busy));
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(e_busy + 1));
        chk({tag, ".done_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, ".err"}, 32'(bus_err_out), 32'(e_err));
        chk({tag, ".ld"}, load_data_out, v.e_ld);
        @(posedge clk); #1;
        chk({tag, ".err_pulse"}, 32'(bus_err_out), 32'd0);
        ld_model = v.e_ld;
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        clear_inputs();

        tbl[0]  = '{1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1, 0, 4'hF, 32'h0, 32'hDEAD_BEEF};
        tbl[1]  = '{1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, 0, 4'h8, 32'h0, 32'hFFFF_FF80};
        tbl[2]  = '{1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, 0, 4'h8, 32'h0, 32'h0000_0080};
        tbl[3]  = '{1, 0, 3'b101, 32'h0000_1002, 32'h0, 32'hF00D_1234, 2, 0, 4'hC, 32'h0, 32'h0000_F00D};
        tbl[4]  = '{0, 1, 3'b000, 32'h0000_1002, 32'h0000_00A5, 32'h0, 1, 0, 4'h4, 32'hA5A5_A5A5, 32'h0000_F00D};
        tbl[5]  = '{0, 1, 3'b001, 32'h0000_1002, 32'h0000_00A5, 32'h0, 1, 0, 4'hC, 32'h00A5_00A5, 32'h0000_F00D};
        tbl[6]  = '{1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0000_F00D};
        tbl[7]  = '{1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 1, 1, 4'h0, 32'h0, 32'h0000_F00D};
        tbl[8]  = '{1, 0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_5555, 3, 0, 4'hC, 32'h0, 32'hFFFF_8001};
        tbl[9]  = '{1, 1, 3'b010, 32'h0000_2000, 32'h1234_5678, 32'h0, 1, 0, 4'hF, 32'h1234_5678, 32'hFFFF_8001};
        tbl[10] = '{0, 1, 3'b100, 32'h0000_3001, 32'hFFFF_FF3C, 32'h0, 2, 0, 4'h2, 32'h3C3C_3C3C, 32'hFFFF_8001};
        tbl[11] = '{1, 0, 3'b010, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, TO, 0, 4'hF, 32'h0, 32'hCAFE_F00D};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.addr", dmem_addr, 32'd0);
        chk("rst.be", 32'(dmem_be), 32'd0);
        chk("rst.wdata", dmem_wdata, 32'd0);
        chk("rst.stall", 32'(mem_stall), 32'd0);
        chk("rst.ld", load_data_out, 32'd0);
        chk("rst.err", 32'(bus_err_out), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) do_access($sformatf("vec%0d", i), tbl[i]);

        // Timeout, then a stray ack in IDLE.
        v = '{1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h1111_2222, 0, 0, 4'hF, 32'h0, 32'h0};
        do_access("timeout", v);
        repeat (2) @(posedge clk);
        #1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        chk("stray.stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("stray.req", 32'(dmem_req), 32'd0);
        chk("stray.ld", load_data_out, 32'd0);
        chk("stray.err", 32'(bus_err_out), 32'd0);
        @(posedge clk); #1;

        // Reset in the 3rd BUSY cycle.
        mem_read_in   = 1'b1;
        mem_funct3_in = 3'b010;
        alu_result_in = 32'h0000_0500;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        chk("midrst.req_before", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.req", 32'(dmem_req), 32'd0);
        chk("midrst.we", 32'(dmem_we), 32'd0);
        chk("midrst.addr", dmem_addr, 32'd0);
        chk("midrst.be", 32'(dmem_be), 32'd0);
        chk("midrst.stall", 32'(mem_stall), 32'd0);
        chk("midrst.ld", load_data_out, 32'd0);
        chk("midrst.mis", 32'(misaligned_out), 32'd0);
        chk("midrst.err", 32'(bus_err_out), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("lateack.ld", load_data_out, 32'd0);
        chk("lateack.req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        ld_model = 32'd0;
        v = '{1, 0, 3'b010, 32'h0000_0600, 32'h0, 32'h7654_3210, 2, 0, 4'hF, 32'h0, 32'h7654_3210};
        do_access("postrst", v);

        // Randomised accesses against the reference model.
        for (int i = 0; i < 60; i++) begin
            int r;
            v.rd    = $urandom_range(0, 1);
            v.wr    = v.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            v.f3    = 3'($urandom_range(0, 7));
            v.addr  = $urandom;
            v.rs2   = $urandom;
            v.rdata = $urandom;
            r = $urandom_range(0, 12);
            v.ackn  = (r == 0) ? 0 : (r == 12) ? TO + 1 : r;
            model(v.rd, v.wr, v.f3, v.addr, v.rs2, v.rdata, v.ackn,
                  v.e_mis, v.e_be, v.e_wdata, v.e_ld);
            do_access($sformatf("rnd%0d", i), v);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
